// File: rtl/encap_mem_wide_value.sv
// Wide-entry lookup memory: DEPTH entries of VALUE_NBITS behind one app read port and PIO.
// Define ENCAP_WIDE_MEM_PARITY_EN to add a stored even-parity bit and the app_parity_err output.
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif
`ifndef PIO_RANGE
`define PIO_RANGE 31:0
`endif
`ifndef PIO_ADDR_MSB
`define PIO_ADDR_MSB 31
`endif

// state  | meaning
// S_IDLE | accepting PIO strobes
// S_REQ  | dword-0 read waiting for the shared array read port
// S_WAIT | array read issued, data arrives this cycle
// S_DATA | snapshot loaded, mem_ack pulsing with dword 0
module encap_mem_wide_value #(
  parameter int VALUE_NBITS  = 416,
  parameter int DEPTH_NBITS  = 8,
  parameter int STARVE_NBITS = 4
) (
  input  logic                   clk,
  input  logic                   `RESET_SIG,
  input  logic [`PIO_RANGE]      reg_addr,
  input  logic [`PIO_RANGE]      reg_din,
  input  logic                   reg_rd,
  input  logic                   reg_wr,
  input  logic                   reg_ms,
  output logic                   mem_ack,
  output logic [`PIO_RANGE]      mem_rdata,
  output logic                   app_rdy,
  input  logic                   app_rd,
  input  logic [DEPTH_NBITS-1:0] app_raddr,
`ifdef ENCAP_WIDE_MEM_PARITY_EN
  output logic                   app_parity_err,
`endif
  output logic                   app_ack,
  output logic [VALUE_NBITS-1:0] app_rdata
);

  localparam int DW_PER_ENTRY = (VALUE_NBITS + 31) / 32;
  localparam int DW_SEL_NBITS = (DW_PER_ENTRY > 1) ? $clog2(DW_PER_ENTRY) : 1;
  localparam int BUF_NBITS    = DW_PER_ENTRY * 32;
  localparam int ENTRY_LSB    = 2 + DW_SEL_NBITS;
  localparam int ENTRY_MSB    = ENTRY_LSB + DEPTH_NBITS - 1;
`ifdef ENCAP_WIDE_MEM_PARITY_EN
  localparam int MEM_NBITS = VALUE_NBITS + 1;
`else
  localparam int MEM_NBITS = VALUE_NBITS;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DATA} state_t;

  state_t                  state;
  logic [STARVE_NBITS-1:0] starve_cnt;
  logic [BUF_NBITS-1:0]    wbuf, snapshot, commit_full, rd_wide;
  logic [MEM_NBITS-1:0]    mem [2**DEPTH_NBITS];
  logic [MEM_NBITS-1:0]    rd_raw, commit_word;
  logic [DEPTH_NBITS-1:0]  commit_entry, pio_entry, rd_addr, entry;
  logic [31:0]             commit_dw;
  logic [DW_SEL_NBITS-1:0] sel;
  logic                    commit_q, app_v1;
  logic                    hole, last_dw, strobe, starved, pio_grant, app_accept;
  logic                    addr_unused;
`ifdef ENCAP_WIDE_MEM_PARITY_EN
  logic                    par_inj, snap_perr, par_dw;
`endif

  assign sel         = reg_addr[2 +: DW_SEL_NBITS];
  assign entry       = reg_addr[ENTRY_LSB +: DEPTH_NBITS];
  assign addr_unused = ^{reg_addr[1:0], reg_addr[`PIO_ADDR_MSB:ENTRY_MSB+1]};
  assign hole        = int'(sel) >= DW_PER_ENTRY;
  assign last_dw     = int'(sel) == DW_PER_ENTRY - 1;
  assign strobe      = reg_ms && (reg_rd || reg_wr) && (state == S_IDLE) && !mem_ack;
  assign starved     = &starve_cnt;
  assign app_rdy     = !((state == S_REQ) && starved);
  assign pio_grant   = (state == S_REQ) && (!app_rd || starved);
  assign app_accept  = app_rd && app_rdy;
  assign rd_addr     = pio_grant ? pio_entry : app_raddr;
  assign rd_wide     = BUF_NBITS'(rd_raw[VALUE_NBITS-1:0]);

  // The final dword arrives with the commit strobe; everything below it comes from the buffer.
  always_comb begin
    commit_full = wbuf;
    commit_full[BUF_NBITS-32 +: 32] = commit_dw;
  end

`ifdef ENCAP_WIDE_MEM_PARITY_EN
  assign par_dw      = int'(sel) == DW_PER_ENTRY;
  assign commit_word = {(^commit_full[VALUE_NBITS-1:0]) ^ par_inj, commit_full[VALUE_NBITS-1:0]};
`else
  assign commit_word = commit_full[VALUE_NBITS-1:0];
`endif

  // Read-first: a commit and a read of the same entry in one cycle returns the old value.
  always_ff @(posedge clk) begin
    if (commit_q) mem[commit_entry] <= commit_word;
    rd_raw <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) begin
      state        <= S_IDLE;
      starve_cnt   <= '0;
      wbuf         <= '0;
      snapshot     <= '0;
      commit_q     <= 1'b0;
      commit_entry <= '0;
      commit_dw    <= '0;
      pio_entry    <= '0;
      app_v1       <= 1'b0;
      mem_ack      <= 1'b0;
      mem_rdata    <= '0;
      app_ack      <= 1'b0;
      app_rdata    <= '0;
`ifdef ENCAP_WIDE_MEM_PARITY_EN
      par_inj        <= 1'b0;
      snap_perr      <= 1'b0;
      app_parity_err <= 1'b0;
`endif
    end else begin
      mem_ack  <= 1'b0;
      commit_q <= 1'b0;
      app_v1   <= app_accept;
      app_ack  <= app_v1;
      if (app_v1) app_rdata <= rd_raw[VALUE_NBITS-1:0];
`ifdef ENCAP_WIDE_MEM_PARITY_EN
      app_parity_err <= app_v1 && (^rd_raw);
      if (commit_q) par_inj <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (strobe && reg_wr) begin
            mem_ack <= 1'b1;
            if (last_dw) begin
              commit_q     <= 1'b1;
              commit_entry <= entry;
              commit_dw    <= reg_din;
            end else if (!hole) begin
              wbuf[{sel, 5'b0} +: 32] <= reg_din;
            end
`ifdef ENCAP_WIDE_MEM_PARITY_EN
            else if (par_dw) begin
              par_inj <= reg_din[0];
            end
`endif
          end else if (strobe && (sel == '0)) begin
            state     <= S_REQ;
            pio_entry <= entry;
          end else if (strobe) begin
            mem_ack <= 1'b1;
            if (!hole) mem_rdata <= snapshot[{sel, 5'b0} +: 32];
`ifdef ENCAP_WIDE_MEM_PARITY_EN
            else if (par_dw) mem_rdata <= {31'b0, snap_perr};
`endif
            else mem_rdata <= '0;
          end
        end
        S_REQ: begin
          if (pio_grant) begin
            state      <= S_WAIT;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          state     <= S_DATA;
          snapshot  <= rd_wide;
          mem_ack   <= 1'b1;
          mem_rdata <= rd_wide[31:0];
`ifdef ENCAP_WIDE_MEM_PARITY_EN
          snap_perr <= ^rd_raw;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  app_rd_protocol: assert property (@(posedge clk) disable iff (!`RESET_SIG) !(app_rd && !app_rdy))
    else $error("app_rd issued while app_rdy low");

endmodule

// File: tb/tb_encap_mem_wide_value.sv
// Self-checking bench for encap_mem_wide_value with a dword-level reference model.
module tb_encap_mem_wide_value;
  localparam int VN = 416;
  localparam int DW = 13;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [31:0]  reg_addr = '0, reg_din = '0;
  logic         reg_rd = 1'b0, reg_wr = 1'b0, reg_ms = 1'b0;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         app_rdy;
  logic         app_rd = 1'b0;
  logic [7:0]   app_raddr = '0;
  logic         app_ack;
  logic [VN-1:0] app_rdata;
`ifdef ENCAP_WIDE_MEM_PARITY_EN
  logic         app_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [VN-1:0] model [256];
  logic [31:0]   buf_m [DW-1];

  typedef struct {logic [VN-1:0] d; int due;} exp_t;

  encap_mem_wide_value dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .app_rdy(app_rdy), .app_rd(app_rd), .app_raddr(app_raddr),
`ifdef ENCAP_WIDE_MEM_PARITY_EN
    .app_parity_err(app_parity_err),
`endif
    .app_ack(app_ack), .app_rdata(app_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pio_addr(input int e, input int s);
    return 32'(e * 64 + s * 4);
  endfunction

  function automatic logic [VN-1:0] entry_from(input logic [31:0] top);
    logic [VN-1:0] v;
    for (int i = 0; i < DW - 1; i++) v[i*32 +: 32] = buf_m[i];
    v[(DW-1)*32 +: 32] = top;
    return v;
  endfunction

  task automatic pio_wr(input int e, input int s, input logic [31:0] d, output bit ack);
    reg_addr = pio_addr(e, s); reg_din = d; reg_wr = 1'b1; reg_ms = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0; reg_ms = 1'b0;
    ack = mem_ack;
    if (s < DW - 1) buf_m[s] = d;
    else if (s == DW - 1) model[e] = entry_from(d);
    @(negedge clk);
  endtask

  task automatic pio_rd(input int e, input int s, output logic [31:0] d, output int lat);
    reg_addr = pio_addr(e, s); reg_rd = 1'b1; reg_ms = 1'b1;
    @(negedge clk);
    reg_rd = 1'b0; reg_ms = 1'b0;
    lat = 0; d = '0;
    for (int i = 1; i <= 40; i++) begin
      if (mem_ack) begin lat = i; d = mem_rdata; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic app_read(input int e, output logic [VN-1:0] d, output int lat);
    app_rd = 1'b1; app_raddr = 8'(e);
    @(negedge clk);
    app_rd = 1'b0;
    lat = 0; d = '0;
    for (int i = 1; i <= 10; i++) begin
      if (app_ack) begin lat = i; d = app_rdata; break; end
      @(negedge clk);
    end
  endtask

  task automatic fill_entry(input int e);
    bit ack;
    for (int i = 0; i < DW; i++) pio_wr(e, i, $urandom, ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL reset_mem_ack got %b exp 0", mem_ack); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got %h exp 0", mem_rdata); end
    checks++; if (app_ack !== 1'b0) begin errors++; $display("FAIL reset_app_ack got %b exp 0", app_ack); end
    checks++; if (app_rdata !== '0) begin errors++; $display("FAIL reset_app_rdata got %h exp 0", app_rdata); end
    checks++; if (app_rdy !== 1'b1) begin errors++; $display("FAIL reset_app_rdy got %b exp 1", app_rdy); end
    rst_n = 1'b1;
    for (int i = 0; i < DW - 1; i++) buf_m[i] = '0;
    @(negedge clk);
  endtask

  task automatic test_commit();
    bit ack; logic [VN-1:0] d; int lat;
    for (int i = 0; i < DW; i++) begin
      pio_wr(5, i, 32'h1000 + 32'(i), ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL commit_wr_ack dw=%0d got %b exp 1", i, ack); end
    end
    app_read(5, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL commit_app_lat got %0d exp 2", lat); end
    for (int i = 0; i < DW; i++) begin
      checks++;
      if (d[i*32 +: 32] !== 32'h1000 + 32'(i))
        begin errors++; $display("FAIL commit_app_dw%0d got %h exp %h", i, d[i*32 +: 32], 32'h1000 + 32'(i)); end
    end
  endtask

  task automatic test_pio_read();
    bit ack; logic [31:0] d; int lat; logic [31:0] top;
    pio_rd(5, 0, d, lat);
    checks++; if (lat !== 3 || d !== 32'h1000) begin errors++; $display("FAIL pio_rd_dw0 got lat %0d data %h exp lat 3 data 00001000", lat, d); end
    pio_rd(5, 7, d, lat);
    checks++; if (lat !== 1 || d !== 32'h1007) begin errors++; $display("FAIL pio_rd_dw7 got lat %0d data %h exp lat 1 data 00001007", lat, d); end
    top = $urandom;
    pio_wr(5, DW - 1, top, ack);
    pio_rd(5, DW - 1, d, lat);
    checks++; if (d !== 32'h100C) begin errors++; $display("FAIL pio_snapshot_stale got %h exp 0000100c", d); end
    pio_rd(5, 0, d, lat);
    checks++; if (lat !== 3 || d !== model[5][31:0]) begin errors++; $display("FAIL pio_rd_refresh got lat %0d data %h exp lat 3 data %h", lat, d, model[5][31:0]); end
    pio_rd(5, DW - 1, d, lat);
    checks++; if (d !== top) begin errors++; $display("FAIL pio_rd_newtop got %h exp %h", d, top); end
  endtask

  task automatic test_partial();
    bit ack; logic [VN-1:0] old, d; int lat;
    fill_entry(6);
    old = model[6];
    for (int i = 0; i < DW - 1; i++) pio_wr(6, i, $urandom, ack);
    app_read(6, d, lat);
    checks++; if (lat !== 2 || d !== old) begin errors++; $display("FAIL partial_no_commit got lat %0d data %h exp %h", lat, d, old); end
  endtask

  task automatic test_holes();
    bit ack; logic [31:0] d; int lat; logic [VN-1:0] v;
    pio_rd(5, 14, d, lat);
    checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL hole_rd got lat %0d data %h exp lat 1 data 0", lat, d); end
    pio_rd(5, DW, d, lat);
    checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL hole13_rd got lat %0d data %h exp lat 1 data 0", lat, d); end
    pio_wr(5, 15, $urandom, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL hole_wr_ack got %b exp 1", ack); end
    app_read(5, v, lat);
    checks++; if (v !== model[5]) begin errors++; $display("FAIL hole_wr_dropped got %h exp %h", v, model[5]); end
  endtask

  task automatic test_busy();
    int acks, first;
    reg_addr = pio_addr(5, 0); reg_rd = 1'b1; reg_ms = 1'b1;
    @(negedge clk);
    reg_addr = pio_addr(5, 3);
    acks = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 2) begin reg_rd = 1'b0; reg_ms = 1'b0; end
      if (mem_ack) begin acks++; if (first == 0) first = i; end
      @(negedge clk);
    end
    checks++; if (acks !== 1 || first !== 3) begin errors++; $display("FAIL busy_strobe_ignored got acks %0d first %0d exp 1 at 3", acks, first); end
  endtask

  task automatic test_starve();
    exp_t q[$]; exp_t x;
    int low_idx, lows, ack_idx, n_ack;
    logic [31:0] ackd;
    reg_addr = pio_addr(5, 0); reg_rd = 1'b1; reg_ms = 1'b1;
    app_rd = 1'b1; app_raddr = 8'd5;
    q.push_back('{model[5], 2});
    low_idx = -1; lows = 0; ack_idx = -1; ackd = '0; n_ack = 0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      reg_rd = 1'b0; reg_ms = 1'b0;
      if (app_ack) begin
        n_ack++;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL starve_app_extra_ack cyc %0d", cyc); end
        else begin
          x = q.pop_front();
          if (x.due !== cyc || app_rdata !== x.d) begin errors++; $display("FAIL starve_app_ack got cyc %0d data %h exp cyc %0d data %h", cyc, app_rdata, x.due, x.d); end
        end
      end
      if (mem_ack && ack_idx < 0) begin ack_idx = cyc; ackd = mem_rdata; end
      if (!app_rdy) begin lows++; if (low_idx < 0) low_idx = cyc; end
      app_rd = (cyc < 28) && app_rdy;
      if (app_rd) q.push_back('{model[5], cyc + 2});
    end
    checks++; if (low_idx !== 16 || lows !== 1) begin errors++; $display("FAIL starve_rdy_low got first %0d count %0d exp 16 1", low_idx, lows); end
    checks++; if (ack_idx !== low_idx + 2) begin errors++; $display("FAIL starve_grant_ack got %0d exp %0d", ack_idx, low_idx + 2); end
    checks++; if (ackd !== model[5][31:0]) begin errors++; $display("FAIL starve_data got %h exp %h", ackd, model[5][31:0]); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL starve_app_missing got %0d pending exp 0", q.size()); end
  endtask

  task automatic test_collision();
    bit ack; logic [VN-1:0] old_v, new_v; logic [31:0] top;
    fill_entry(9);
    old_v = model[9];
    for (int i = 0; i < DW - 1; i++) pio_wr(9, i, $urandom, ack);
    top = $urandom;
    reg_addr = pio_addr(9, DW - 1); reg_din = top; reg_wr = 1'b1; reg_ms = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0; reg_ms = 1'b0;
    app_rd = 1'b1; app_raddr = 8'd9;
    model[9] = entry_from(top);
    new_v = model[9];
    checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL collide_commit_ack got %b exp 1", mem_ack); end
    @(negedge clk);
    @(negedge clk);
    app_rd = 1'b0;
    checks++; if (app_ack !== 1'b1 || app_rdata !== old_v) begin errors++; $display("FAIL collide_old got ack %b data %h exp %h", app_ack, app_rdata, old_v); end
    @(negedge clk);
    checks++; if (app_ack !== 1'b1 || app_rdata !== new_v) begin errors++; $display("FAIL collide_new got ack %b data %h exp %h", app_ack, app_rdata, new_v); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t x;
    int picks[3] = '{5, 6, 9};
    int idx;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (app_ack) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra_ack cyc %0d", cyc); end
        else begin
          x = q.pop_front();
          if (x.due !== cyc || app_rdata !== x.d) begin errors++; $display("FAIL b2b_ack got cyc %0d data %h exp cyc %0d data %h", cyc, app_rdata, x.due, x.d); end
        end
      end
      if (cyc < 56 && $urandom_range(0, 3) != 0) begin
        idx = picks[$urandom_range(0, 2)];
        app_rd = 1'b1; app_raddr = 8'(idx);
        q.push_back('{model[idx], cyc + 2});
      end else begin
        app_rd = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL b2b_missing got %0d pending exp 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    int acks; logic [31:0] d; int lat;
    reg_addr = pio_addr(5, 0); reg_rd = 1'b1; reg_ms = 1'b1;
    @(negedge clk);
    reg_rd = 1'b0; reg_ms = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (mem_ack !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL midrst_pio got ack %b data %h exp 0 0", mem_ack, mem_rdata); end
    checks++; if (app_ack !== 1'b0 || app_rdata !== '0 || app_rdy !== 1'b1) begin errors++; $display("FAIL midrst_app got ack %b rdy %b data %h exp 0 1 0", app_ack, app_rdy, app_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DW - 1; i++) buf_m[i] = '0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_ack || app_ack) acks++;
      @(negedge clk);
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midrst_dropped got %0d acks exp 0", acks); end
    pio_rd(5, 3, d, lat);
    checks++; if (lat !== 1 || d !== 32'h0) begin errors++; $display("FAIL midrst_snapshot got lat %0d data %h exp lat 1 data 0", lat, d); end
    pio_rd(5, 0, d, lat);
    checks++; if (lat !== 3 || d !== model[5][31:0]) begin errors++; $display("FAIL midrst_reread got lat %0d data %h exp lat 3 data %h", lat, d, model[5][31:0]); end
  endtask

`ifdef ENCAP_WIDE_MEM_PARITY_EN
  task automatic test_parity();
    bit ack; logic [31:0] d; int lat;
    pio_wr(7, DW, 32'h1, ack);
    fill_entry(7);
    app_rd = 1'b1; app_raddr = 8'd7;
    @(negedge clk); app_rd = 1'b0;
    @(negedge clk);
    checks++; if (app_ack !== 1'b1 || app_parity_err !== 1'b1 || app_rdata !== model[7]) begin errors++; $display("FAIL parity_inject got ack %b err %b exp 1 1", app_ack, app_parity_err); end
    pio_rd(7, 0, d, lat);
    pio_rd(7, DW, d, lat);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL parity_pio_dw got %h exp 1", d); end
    pio_wr(7, DW - 1, $urandom, ack);
    app_rd = 1'b1; app_raddr = 8'd7;
    @(negedge clk); app_rd = 1'b0;
    @(negedge clk);
    checks++; if (app_ack !== 1'b1 || app_parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean got ack %b err %b exp 1 0", app_ack, app_parity_err); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_commit();
    test_pio_read();
    test_partial();
    test_holes();
    test_busy();
    test_starve();
    test_collision();
    test_back_to_back();
    test_reset_mid();
`ifdef ENCAP_WIDE_MEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
